// File: rtl/v_pkg.sv
// Shared types for the list engine and its update ingress.
// The FIFO word bundles one host update command.
package v_pkg;

    typedef logic [7:0] id_t;

    typedef enum logic [1:0] {
        CMD_INS = 2'd0,
        CMD_DEL = 2'd1,
        CMD_SET = 2'd2,
        CMD_NOP = 2'd3
    } cmd_t;

    typedef logic [15:0] key_t;
    typedef logic [7:0]  size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

    localparam int UPD_INGRESS_DEPTH = 8;

endpackage

// File: rtl/v_upd_ingress_if.sv
// Host-side update command handshake into the ingress stage.
// The host is the master; the ingress is the slave.
interface v_upd_ingress_if;
    import v_pkg::*;

    logic  i_in_vld;
    logic  o_in_rdy;
    id_t   i_in_prod_id;
    cmd_t  i_in_cmd;
    key_t  i_in_key;
    size_t i_in_size;

    modport master (
        output i_in_vld,
        output i_in_prod_id,
        output i_in_cmd,
        output i_in_key,
        output i_in_size,
        input  o_in_rdy
    );

    modport slave (
        input  i_in_vld,
        input  i_in_prod_id,
        input  i_in_cmd,
        input  i_in_key,
        input  i_in_size,
        output o_in_rdy
    );

endinterface

// File: rtl/v_ingress_fifo.sv
// Command FIFO for the update ingress: storage, pointers,
// registered level/full/empty and synchronous flush.
module v_ingress_fifo
    import v_pkg::*;
#(
    parameter int DEPTH = UPD_INGRESS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  upd_t                       wdata,
    output upd_t                       head,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    upd_t          mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [LW-1:0] lvl_nxt;

    assign head = mem[rp];

    always_comb begin
        lvl_nxt = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            level <= lvl_nxt;
            full  <= (lvl_nxt == LW'(DEPTH));
            empty <= (lvl_nxt == '0);
        end
    end

endmodule

// File: rtl/v_upd_ingress.sv
// Update ingress: buffers host commands and issues them to the
// list engine, holding off on busy and same-id spacing hazards.
module v_upd_ingress
    import v_pkg::*;
#(
    parameter int DEPTH = UPD_INGRESS_DEPTH,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    v_upd_ingress_if.slave             host,
    input  logic                       i_flush,
    input  logic                       i_busy,
    output logic                       o_upd_vld_r,
    output id_t                        o_upd_prod_id_r,
    output cmd_t                       o_upd_cmd_r,
    output key_t                       o_upd_key_r,
    output size_t                      o_upd_size_r,
    output logic [$clog2(DEPTH+1)-1:0] o_level_r,
    output logic                       o_full_r,
    output logic                       o_empty_r,
    output logic [15:0]                o_stall_cnt_r
);

    logic push;
    logic issue;
    logic hazard;
    upd_t wdata;
    upd_t head;

    assign host.o_in_rdy = !o_full_r;

    assign wdata = '{prod_id: host.i_in_prod_id,
                     cmd:     host.i_in_cmd,
                     key:     host.i_in_key,
                     size:    host.i_in_size};

    assign push  = host.i_in_vld & !o_full_r & !i_flush;
    assign issue = !o_empty_r & !i_busy & !hazard & !i_flush;

    v_ingress_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .flush (i_flush),
        .wdata (wdata),
        .head  (head),
        .level (o_level_r),
        .full  (o_full_r),
        .empty (o_empty_r)
    );

    // Slot k holds the issue made k+1 cycles ago.
    if (GAP > 0) begin : g_hist
        logic [GAP-1:0] hv;
        id_t            hid [GAP];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hv <= '0;
                for (int k = 0; k < GAP; k++) hid[k] <= '0;
            end else begin
                hv[0]  <= issue;
                hid[0] <= head.prod_id;
                for (int k = 1; k < GAP; k++) begin
                    hv[k]  <= hv[k-1] & !i_flush;
                    hid[k] <= hid[k-1];
                end
            end
        end

        always_comb begin
            hazard = 1'b0;
            for (int k = 0; k < GAP; k++) begin
                if (hv[k] && (hid[k] == head.prod_id)) hazard = 1'b1;
            end
        end
    end else begin : g_no_hist
        assign hazard = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stall_cnt_r <= '0;
        end else if (!o_empty_r && !i_busy && hazard
                     && (o_stall_cnt_r != 16'hFFFF)) begin
            o_stall_cnt_r <= o_stall_cnt_r + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= CMD_INS;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
        end else begin
            o_upd_vld_r <= issue;
            if (issue) begin
                o_upd_prod_id_r <= head.prod_id;
                o_upd_cmd_r     <= head.cmd;
                o_upd_key_r     <= head.key;
                o_upd_size_r    <= head.size;
            end
        end
    end

endmodule
